// File: rtl/minibyte_mmio_pkg.sv
// Shared definitions for the minibyte MMIO block: register offsets,
// timer control bit positions and the UART transmitter state type.
package minibyte_mmio_pkg;

    localparam logic [3:0] OFS_GPIO_OUT  = 4'h0;
    localparam logic [3:0] OFS_GPIO_IN   = 4'h1;
    localparam logic [3:0] OFS_TMR_CNT   = 4'h2;
    localparam logic [3:0] OFS_TMR_CMP   = 4'h3;
    localparam logic [3:0] OFS_TMR_CTRL  = 4'h4;
    localparam logic [3:0] OFS_UART_DATA = 4'h5;
    localparam logic [3:0] OFS_UART_STAT = 4'h6;

    localparam int TMR_CTRL_EN_BIT    = 0;
    localparam int TMR_CTRL_MATCH_BIT = 1;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/minibyte_uart_tx.sv
// Byte-wide UART transmitter: one start bit, 8 data bits LSB first, one stop bit.
// The line is driven from the state register, so reset returns it high at once.
module minibyte_uart_tx
    import minibyte_mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ena_in,
    input  logic       start_in,
    input  logic [7:0] data_in,
    output logic       busy_out,
    output logic       tx_out
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_e   state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          bit_done;

    assign bit_done = (clk_cnt_q == CLK_LAST);
    assign busy_out = (state_q != UART_IDLE);

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_out    = 1'b1;
        case (state_q)
            UART_IDLE: begin
                if (start_in) begin
                    state_d   = UART_START;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    shift_d   = data_in;
                end
            end
            UART_START: begin
                tx_out = 1'b0;
                if (bit_done) begin
                    clk_cnt_d = '0;
                    state_d   = UART_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            UART_DATA: begin
                tx_out = shift_q[0];
                if (bit_done) begin
                    clk_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = UART_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            UART_STOP: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    state_d   = UART_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= UART_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else if (ena_in) begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

endmodule

// File: rtl/minibyte_mmio.sv
// minibyte MMIO peripheral: address decode, GPIO, prescaled timer and UART TX.
// The UART is built only when MINIBYTE_MMIO_UART_EN is defined.
module minibyte_mmio
    import minibyte_mmio_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR    = 8'hF0,
    parameter int          TMR_PRESCALE = 4,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ena_in,
    input  logic [7:0] addr_in,
    input  logic [7:0] wr_data_in,
    input  logic       we_in,
    output logic [7:0] rd_data_out,
    output logic       hit_out,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
    output logic       tmr_match_out,
    output logic       uart_tx_out
);

    localparam int PW = (TMR_PRESCALE > 1) ? $clog2(TMR_PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TMR_PRESCALE - 1);

    logic [3:0]    offset;
    logic          wr_en;
    logic [7:0]    gpio_q, gpio_d;
    logic [7:0]    sync1_q, sync2_q;
    logic [7:0]    cnt_q, cnt_d, cnt_inc;
    logic [7:0]    cmp_q, cmp_d;
    logic          en_q, en_d;
    logic          match_q, match_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick, set_match;
    logic          uart_busy;

    assign offset        = addr_in[3:0];
    assign hit_out       = (addr_in[7:4] == BASE_ADDR[7:4]);
    assign wr_en         = we_in & hit_out & ena_in;
    assign gpio_out      = gpio_q;
    assign tmr_match_out = match_q;
    assign tick          = en_q && (presc_q == PRESC_LAST);
    assign cnt_inc       = cnt_q + 8'd1;
    assign set_match     = tick && (cnt_inc == cmp_q);

    always_comb begin
        gpio_d  = gpio_q;
        cnt_d   = cnt_q;
        cmp_d   = cmp_q;
        en_d    = en_q;
        match_d = match_q;
        presc_d = presc_q;
        if (en_q) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                cnt_d = cnt_inc;
            end
        end
        if (wr_en) begin
            case (offset)
                OFS_GPIO_OUT: gpio_d = wr_data_in;
                OFS_TMR_CNT: begin
                    cnt_d   = wr_data_in;
                    presc_d = '0;
                end
                OFS_TMR_CMP: cmp_d = wr_data_in;
                OFS_TMR_CTRL: begin
                    en_d = wr_data_in[TMR_CTRL_EN_BIT];
                    if (wr_data_in[TMR_CTRL_MATCH_BIT]) begin
                        match_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        // A match set in the same cycle as a software clear must survive.
        if (set_match) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            gpio_q  <= 8'h00;
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
            cnt_q   <= 8'h00;
            cmp_q   <= 8'hFF;
            en_q    <= 1'b0;
            match_q <= 1'b0;
            presc_q <= '0;
        end else if (ena_in) begin
            gpio_q  <= gpio_d;
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            cmp_q   <= cmp_d;
            en_q    <= en_d;
            match_q <= match_d;
            presc_q <= presc_d;
        end
    end

`ifdef MINIBYTE_MMIO_UART_EN
    minibyte_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .ena_in  (ena_in),
        .start_in(wr_en && (offset == OFS_UART_DATA)),
        .data_in (wr_data_in),
        .busy_out(uart_busy),
        .tx_out  (uart_tx_out)
    );
`else
    logic unused_uart_cfg;
    assign unused_uart_cfg = (CLKS_PER_BIT > 0);
    assign uart_busy       = 1'b0;
    assign uart_tx_out     = 1'b1;
`endif

    always_comb begin
        rd_data_out = 8'h00;
        if (hit_out) begin
            case (offset)
                OFS_GPIO_OUT:  rd_data_out = gpio_q;
                OFS_GPIO_IN:   rd_data_out = sync2_q;
                OFS_TMR_CNT:   rd_data_out = cnt_q;
                OFS_TMR_CMP:   rd_data_out = cmp_q;
                OFS_TMR_CTRL:  rd_data_out = {6'b0, match_q, en_q};
                OFS_UART_STAT: rd_data_out = {7'b0, uart_busy};
                default:       rd_data_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_minibyte_mmio.sv
// Self-checking bench for minibyte_mmio: reset/read table, scripted timer,
// GPIO and UART sequences, and a randomized run against a register-level model.
module tb_minibyte_mmio;

    localparam int P   = 4;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       we = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] gpio_in = 8'h00;
    logic [7:0] rd_data, gpio_out;
    logic       hit, match, tx;

    int n_checks = 0;
    int n_fail   = 0;

    minibyte_mmio #(
        .BASE_ADDR(8'hF0), .TMR_PRESCALE(P), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk_in(clk), .rst_in(rst_n), .ena_in(ena), .addr_in(addr),
        .wr_data_in(wdata), .we_in(we), .rd_data_out(rd_data), .hit_out(hit),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .tmr_match_out(match),
        .uart_tx_out(tx)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp_data;
        logic       exp_hit;
    } rd_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Register-level reference model
    logic [7:0] m_gpio, m_cmp, h1, h2;
    int         m_load, m_ticks;
    logic       m_en, m_match;

    task automatic model_reset();
        m_gpio = 8'h00; m_cmp = 8'hFF; m_load = 0; m_ticks = 0;
        m_en = 1'b0; m_match = 1'b0; h1 = 8'h00; h2 = 8'h00;
    endtask

    function automatic logic [7:0] m_cnt();
        return 8'((m_load + m_ticks / P) % 256);
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        if (a[7:4] != 4'hF) return 8'h00;
        case (a[3:0])
            4'h0:    return m_gpio;
            4'h1:    return h2;
            4'h2:    return m_cnt();
            4'h3:    return m_cmp;
            4'h4:    return {6'b0, m_match, m_en};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step();
        logic set;
        int   nt;
        set = 1'b0;
        if (!ena) return;
        if (m_en) begin
            nt = m_ticks + 1;
            if ((nt % P) == 0 && 8'((m_load + nt / P) % 256) == m_cmp) set = 1'b1;
            m_ticks = nt;
        end
        if (we && addr[7:4] == 4'hF) begin
            case (addr[3:0])
                4'h0: m_gpio = wdata;
                4'h2: begin m_load = int'(wdata); m_ticks = 0; end
                4'h3: m_cmp = wdata;
                4'h4: begin m_en = wdata[0]; if (wdata[1]) m_match = 1'b0; end
                default: ;
            endcase
        end
        if (set) m_match = 1'b1;
        h2 = h1;
        h1 = gpio_in;
    endtask

`ifdef MINIBYTE_MMIO_UART_EN
    task automatic uart_frame(input logic [7:0] b);
        logic [9:0] frame;
        logic [7:0] v;
        frame = {1'b1, b, 1'b0};
        wr(8'hF5, b);
        for (int k = 0; k < 10 * CPB; k++) begin
            if (k == 50 || k == 10 * CPB - 1) begin
                addr = 8'hF5; wdata = 8'hFF; we = 1'b1;
                #1;
                check("uart_tx_bit", tx, frame[k / CPB]);
            end else begin
                rd(8'hF6, v);
                check("uart_tx_bit", tx, frame[k / CPB]);
                check("uart_busy", v, 8'h01);
            end
            @(negedge clk);
            we = 1'b0;
        end
        rd(8'hF6, v);
        check("uart_busy_end", v, 8'h00);
        for (int k = 0; k < 20; k++) begin
            #1;
            check("uart_idle_line", tx, 1'b1);
            @(negedge clk);
        end
    endtask
`endif

    rd_vec_t    vec[10];
    logic [7:0] v;

    initial begin
        vec[0] = '{8'hF0, 8'h00, 1'b1};
        vec[1] = '{8'hF1, 8'h00, 1'b1};
        vec[2] = '{8'hF2, 8'h00, 1'b1};
        vec[3] = '{8'hF3, 8'hFF, 1'b1};
        vec[4] = '{8'hF4, 8'h00, 1'b1};
        vec[5] = '{8'hF5, 8'h00, 1'b1};
        vec[6] = '{8'hF6, 8'h00, 1'b1};
        vec[7] = '{8'hF9, 8'h00, 1'b1};
        vec[8] = '{8'h10, 8'h00, 1'b0};
        vec[9] = '{8'hE3, 8'h00, 1'b0};

        tick(2);
        check("tx_in_reset", tx, 1'b1);
        rst_n = 1'b1;
        tick(1);
        check("gpio_out_reset", gpio_out, 8'h00);
        check("match_reset", match, 1'b0);
        check("tx_reset", tx, 1'b1);
        for (int i = 0; i < 10; i++) begin
            rd(vec[i].addr, v);
            check("reset_read", v, vec[i].exp_data);
            check("reset_hit", hit, vec[i].exp_hit);
        end

        // GPIO
        wr(8'hF0, 8'hA5);
        check("gpio_out_write", gpio_out, 8'hA5);
        gpio_in = 8'h3C;
        rd(8'hF1, v); check("gpio_in_lat0", v, 8'h00);
        tick(1);
        rd(8'hF1, v); check("gpio_in_lat1", v, 8'h00);
        tick(1);
        rd(8'hF1, v); check("gpio_in_lat2", v, 8'h3C);

        // Timer compare and match clear
        wr(8'hF3, 8'h03);
        wr(8'hF4, 8'h01);
        tick(11);
        rd(8'hF2, v); check("tmr_cnt_11", v, 8'h02);
        check("tmr_match_early", match, 1'b0);
        tick(1);
        rd(8'hF2, v); check("tmr_cnt_12", v, 8'h03);
        check("tmr_match_set", match, 1'b1);
        wr(8'hF4, 8'h03);
        check("tmr_match_clear", match, 1'b0);
        rd(8'hF4, v); check("tmr_ctrl_after_clear", v, 8'h01);

        // Set and clear in the same cycle: set wins
        wr(8'hF4, 8'h00);
        wr(8'hF2, 8'h02);
        wr(8'hF4, 8'h01);
        tick(3);
        wr(8'hF4, 8'h03);
        check("tmr_set_wins", match, 1'b1);
        rd(8'hF2, v); check("tmr_cnt_set_wins", v, 8'h03);
        wr(8'hF4, 8'h03);

        // Wrap and global enable freeze
        wr(8'hF2, 8'hFE);
        tick(3);
        rd(8'hF2, v); check("tmr_cnt_fe", v, 8'hFE);
        tick(1);
        rd(8'hF2, v); check("tmr_cnt_ff", v, 8'hFF);
        tick(4);
        rd(8'hF2, v); check("tmr_cnt_wrap", v, 8'h00);
        ena = 1'b0;
        wr(8'hF0, 8'h11);
        tick(9);
        rd(8'hF2, v); check("tmr_cnt_frozen", v, 8'h00);
        check("gpio_frozen", gpio_out, 8'hA5);
        ena = 1'b1;
        tick(4);
        rd(8'hF2, v); check("tmr_cnt_resume", v, 8'h01);

        // Randomized run against the model
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            ena     = ($urandom_range(9) != 0);
            gpio_in = 8'($urandom);
            if ($urandom_range(7) == 0) addr = 8'($urandom_range(0, 8'hEF));
            else                        addr = {4'hF, 4'($urandom_range(0, 15))};
            we    = ($urandom_range(1) == 1) && (addr != 8'hF5);
            wdata = 8'($urandom);
            if (addr == 8'hF2 || addr == 8'hF3) wdata = 8'($urandom_range(0, 7));
            #1;
            check("rand_hit", hit, addr[7:4] == 4'hF);
            check("rand_read", rd_data, m_read(addr));
            check("rand_gpio_out", gpio_out, m_gpio);
            check("rand_match", match, m_match);
            @(negedge clk);
            model_step();
        end
        we  = 1'b0;
        ena = 1'b1;

`ifdef MINIBYTE_MMIO_UART_EN
        uart_frame(8'h55);
        // Reset mid-DATA drops the frame and idles the line at once
        wr(8'hF5, 8'hF0);
        tick(40);
        #1;
        check("uart_tx_before_rst", tx, 1'b0);
        rst_n = 1'b0;
        #1;
        check("uart_tx_async_rst", tx, 1'b1);
        rd(8'hF6, v); check("uart_busy_async_rst", v, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        uart_frame(8'hA3);
`else
        wr(8'hF5, 8'h55);
        for (int k = 0; k < 20; k++) begin
            rd(8'hF6, v);
            check("uart_stat_absent", v, 8'h00);
            check("uart_tx_absent", tx, 1'b1);
            @(negedge clk);
        end
        rd(8'hF5, v); check("uart_data_read", v, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
